// File: rtl/rtc_pkg.sv
// Shared register map, bit indices and helpers for the APB4 real-time counter.
// Alarm support is selected with the RTC_ALARM_EN macro.
package rtc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned ISTA_W = 3;

  // Word index taken from paddr[4:2]; indices 5..7 are unmapped.
  typedef enum logic [2:0] {
    REG_CTRL = 3'd0,
    REG_PSCR = 3'd1,
    REG_CNT  = 3'd2,
    REG_ALRM = 3'd3,
    REG_ISTA = 3'd4
  } reg_idx_e;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_SECIE  = 1;
  localparam int unsigned CTRL_ALRMIE = 2;
  localparam int unsigned CTRL_OVIE   = 3;

  localparam int unsigned ISTA_SECIF  = 0;
  localparam int unsigned ISTA_ALRMIF = 1;
  localparam int unsigned ISTA_OVIF   = 2;

  function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [3:0]        strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_core.sv
// Prescaler, seconds counter, alarm compare and flag-set pulses.
// The alarm comparator exists only when RTC_ALARM_EN is defined.
module rtc_core
  import rtc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] pscr_i,
  input  logic              pscr_wr_i,
  input  logic              cnt_wr_i,
  input  logic [DATA_W-1:0] cnt_wdata_i,
`ifdef RTC_ALARM_EN
  input  logic [DATA_W-1:0] alrm_i,
`endif
  output logic [DATA_W-1:0] cnt_o,
  output logic              sec_set_o,
  output logic              alrm_set_o,
  output logic              ov_set_o
);

  logic [DATA_W-1:0] div_q, div_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              div_hit;
  logic              tick;

  always_comb begin
    div_hit    = (div_q == pscr_i);
    // A bus write of CNT swallows a coincident tick entirely.
    tick       = en_i && div_hit && !cnt_wr_i;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sec_set_o  = 1'b0;
    alrm_set_o = 1'b0;
    ov_set_o   = 1'b0;
    if (en_i) div_d = div_hit ? '0 : div_q + 32'd1;
    if (cnt_wr_i || pscr_wr_i) div_d = '0;
    if (cnt_wr_i) begin
      cnt_d = cnt_wdata_i;
    end else if (tick) begin
      cnt_d     = cnt_q + 32'd1;
      sec_set_o = 1'b1;
      ov_set_o  = (cnt_q == '1);
`ifdef RTC_ALARM_EN
      alrm_set_o = ((cnt_q + 32'd1) == alrm_i);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/apb4_rtc_unit.sv
// APB4 real-time counter: bus decode, register file, W1C status and interrupt.
// Define RTC_ALARM_EN to implement the ALRM register, ALRMIF and ALRMIE.
module apb4_rtc_unit
  import rtc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [2:0]            pprot_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic                  pready_o,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pslverr_o,
  output logic                  irq_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pscr_q, pscr_d;
  logic [ISTA_W-1:0] ista_q, ista_d;
`ifdef RTC_ALARM_EN
  logic [DATA_W-1:0] alrm_q, alrm_d;
`endif

  reg_idx_e          idx;
  logic              mapped;
  logic              wr_en;
  logic              pscr_wr, cnt_wr;
  logic [DATA_W-1:0] cnt_val, cnt_wdata;
  logic [ISTA_W-1:0] w1c, set_vec;
  logic              sec_set, alrm_set, ov_set;
  logic              unused_bits;

  assign unused_bits = ^{pprot_i, paddr_i[ADDR_WIDTH-1:5], paddr_i[1:0]};

  assign idx       = reg_idx_e'(paddr_i[4:2]);
  assign mapped    = (paddr_i[4:2] <= 3'd4);
  assign wr_en     = psel_i && penable_i && pwrite_i && mapped;
  assign pready_o  = 1'b1;
  assign pslverr_o = psel_i && penable_i && !mapped;

  assign pscr_wr   = wr_en && (idx == REG_PSCR);
  assign cnt_wr    = wr_en && (idx == REG_CNT);
  assign cnt_wdata = merge_strb(cnt_val, pwdata_i, pstrb_i);

  rtc_core u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (ctrl_q[CTRL_EN]),
    .pscr_i      (pscr_q),
    .pscr_wr_i   (pscr_wr),
    .cnt_wr_i    (cnt_wr),
    .cnt_wdata_i (cnt_wdata),
`ifdef RTC_ALARM_EN
    .alrm_i      (alrm_q),
`endif
    .cnt_o       (cnt_val),
    .sec_set_o   (sec_set),
    .alrm_set_o  (alrm_set),
    .ov_set_o    (ov_set)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    pscr_d = pscr_q;
`ifdef RTC_ALARM_EN
    alrm_d = alrm_q;
`endif
    w1c = '0;
    if (wr_en && (idx == REG_CTRL) && pstrb_i[0]) begin
      ctrl_d = pwdata_i[CTRL_W-1:0];
`ifndef RTC_ALARM_EN
      ctrl_d[CTRL_ALRMIE] = 1'b0;
`endif
    end
    if (pscr_wr) pscr_d = merge_strb(pscr_q, pwdata_i, pstrb_i);
`ifdef RTC_ALARM_EN
    if (wr_en && (idx == REG_ALRM)) alrm_d = merge_strb(alrm_q, pwdata_i, pstrb_i);
`endif
    if (wr_en && (idx == REG_ISTA) && pstrb_i[0]) w1c = pwdata_i[ISTA_W-1:0];
    // Hardware set is OR-ed after the clear so a coincident event is never lost.
    set_vec = '0;
    set_vec[ISTA_SECIF]  = sec_set;
    set_vec[ISTA_ALRMIF] = alrm_set;
    set_vec[ISTA_OVIF]   = ov_set;
    ista_d = (ista_q & ~w1c) | set_vec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      pscr_q <= '0;
      ista_q <= '0;
`ifdef RTC_ALARM_EN
      alrm_q <= '0;
`endif
    end else begin
      ctrl_q <= ctrl_d;
      pscr_q <= pscr_d;
      ista_q <= ista_d;
`ifdef RTC_ALARM_EN
      alrm_q <= alrm_d;
`endif
    end
  end

  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i && mapped) begin
      case (idx)
        REG_CTRL: prdata_o = {{(DATA_WIDTH-CTRL_W){1'b0}}, ctrl_q};
        REG_PSCR: prdata_o = pscr_q;
        REG_CNT:  prdata_o = cnt_val;
`ifdef RTC_ALARM_EN
        REG_ALRM: prdata_o = alrm_q;
`endif
        REG_ISTA: prdata_o = {{(DATA_WIDTH-ISTA_W){1'b0}}, ista_q};
        default:  prdata_o = '0;
      endcase
    end
  end

  assign irq_o = |(ista_q & {ctrl_q[CTRL_OVIE], ctrl_q[CTRL_ALRMIE], ctrl_q[CTRL_SECIE]});

endmodule

// File: tb/tb_apb4_rtc_unit.sv
// Directed bench for apb4_rtc_unit: register vector table plus timed tick sequences.
// Alarm expectations follow the RTC_ALARM_EN macro.
module tb_apb4_rtc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr, irq;
  logic [31:0] prdata;

  int n_vec = 0;
  int n_err = 0;

  apb4_rtc_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pprot_i(pprot),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready),
    .prdata_o(prdata), .pslverr_o(pslverr), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

`ifdef RTC_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] e, input bit err);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.exp_rdata = e; v.exp_err = err;
    vecs.push_back(v);
  endtask

  // Full two-phase access; the write commits at the edge ending the access phase.
  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic err, output logic rdy);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rd = prdata; err = pslverr; rdy = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rd; logic e, r;
    apb(1'b1, a, d, 4'hF, rd, e, r);
  endtask

  // Combinational read without advancing the clock.
  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    check(name, prdata, exp);
    psel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        e, r;

    add(0, 12'h000, 0, 4'h0, 32'h0, 0);
    add(0, 12'h004, 0, 4'h0, 32'h0, 0);
    add(0, 12'h008, 0, 4'h0, 32'h0, 0);
    add(0, 12'h00C, 0, 4'h0, 32'h0, 0);
    add(0, 12'h010, 0, 4'h0, 32'h0, 0);
    add(1, 12'h008, 32'hAABBCCDD, 4'b0001, 32'h0, 0);
    add(0, 12'h008, 0, 4'h0, 32'h000000DD, 0);
    add(1, 12'h008, 32'h11223344, 4'b1100, 32'h0, 0);
    add(0, 12'h008, 0, 4'h0, 32'h112200DD, 0);
    add(1, 12'h018, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(0, 12'h018, 0, 4'h0, 32'h0, 1);
    add(0, 12'h008, 0, 4'h0, 32'h112200DD, 0);
    add(1, 12'h004, 32'h12345678, 4'hF, 32'h0, 0);
    add(0, 12'h004, 0, 4'h0, 32'h12345678, 0);
    add(1, 12'h000, 32'hFFFFFFF6, 4'hF, 32'h0, 0);
    add(0, 12'h000, 0, 4'h0, ALARM ? 32'h6 : 32'h2, 0);
    add(1, 12'h00C, 32'hCAFE0001, 4'hF, 32'h0, 0);
    add(0, 12'h00C, 0, 4'h0, ALARM ? 32'hCAFE0001 : 32'h0, 0);
    add(1, 12'h014, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(0, 12'h01C, 0, 4'h0, 32'h0, 1);
    add(0, 12'h010, 0, 4'h0, 32'h0, 0);
    add(0, 12'hF08, 0, 4'h0, 32'h112200DD, 0);

    do_reset();
    check("reset_irq", {31'b0, irq}, 32'h0);
    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, e, r);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_slverr", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_ready", i), {31'b0, r}, 32'h1);
    end
    check("table_irq", {31'b0, irq}, 32'h0);

    // Prescaler of 4 with SECIE, then W1C of SECIF.
    do_reset();
    wr(12'h004, 32'd3);
    wr(12'h000, 32'h3);
    peek("psc_cnt_e0", 12'h008, 32'd0);
    repeat (3) @(posedge clk); #1;
    peek("psc_cnt_e3", 12'h008, 32'd0);
    check("psc_irq_e3", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("psc_irq_e4", {31'b0, irq}, 32'h1);
    peek("psc_cnt_e4", 12'h008, 32'd1);
    peek("psc_ista_e4", 12'h010, 32'h1);
    repeat (4) @(posedge clk); #1;
    peek("psc_cnt_e8", 12'h008, 32'd2);
    wr(12'h010, 32'h1);
    check("psc_irq_clr", {31'b0, irq}, 32'h0);
    peek("psc_ista_clr", 12'h010, 32'h0);
    peek("psc_cnt_e11", 12'h008, 32'd2);
    @(posedge clk); #1;
    check("psc_irq_e12", {31'b0, irq}, 32'h1);
    peek("psc_cnt_e12", 12'h008, 32'd3);

    // Overflow, set-beats-clear, CNT write priority, reset mid-run.
    do_reset();
    wr(12'h008, 32'hFFFFFFFE);
    wr(12'h004, 32'd0);
    wr(12'h000, 32'h9);
    peek("ov_cnt_e0", 12'h008, 32'hFFFFFFFE);
    @(posedge clk); #1;
    check("ov_irq_e1", {31'b0, irq}, 32'h0);
    peek("ov_cnt_e1", 12'h008, 32'hFFFFFFFF);
    peek("ov_ista_e1", 12'h010, 32'h1);
    @(posedge clk); #1;
    check("ov_irq_e2", {31'b0, irq}, 32'h1);
    peek("ov_cnt_e2", 12'h008, 32'h0);
    peek("ov_ista_e2", 12'h010, 32'h5);
    wr(12'h010, 32'h1);
    peek("set_wins", 12'h010, 32'h5);
    wr(12'h010, 32'h4);
    peek("ovif_clr", 12'h010, 32'h1);
    check("ovif_clr_irq", {31'b0, irq}, 32'h0);
    wr(12'h008, 32'h100);
    peek("cnt_wr_prio", 12'h008, 32'h100);
    @(posedge clk); #1;
    peek("cnt_after_wr", 12'h008, 32'h101);
    wr(12'h000, 32'hB);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    peek("mid_rst_cnt", 12'h008, 32'h0);
    peek("mid_rst_ctrl", 12'h000, 32'h0);

    // Alarm at CNT==5, EN dropped on that same edge.
    do_reset();
    wr(12'h00C, 32'd5);
    wr(12'h008, 32'd0);
    wr(12'h004, 32'd0);
    wr(12'h000, 32'h5);
    @(posedge clk); #1;
    peek("al_cnt_e1", 12'h008, 32'd1);
    repeat (2) @(posedge clk); #1;
    peek("al_cnt_e3", 12'h008, 32'd3);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h4; pstrb = 4'hF;
    @(posedge clk); #1;
    check("al_irq_e4", {31'b0, irq}, 32'h0);
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("al_irq_e5", {31'b0, irq}, ALARM ? 32'h1 : 32'h0);
    peek("al_cnt_e5", 12'h008, 32'd5);
    peek("al_ista_e5", 12'h010, ALARM ? 32'h3 : 32'h1);
    repeat (3) @(posedge clk); #1;
    peek("al_cnt_frozen", 12'h008, 32'd5);
    peek("al_reg", 12'h00C, ALARM ? 32'd5 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
